sprite_tile_fetcher: RTL

- Sits directly downstream of the sprite matcher.
- Once per line it walks the matcher's active-sprite list for line+1 by driving `sprite_index`. For each active sprite it fetches one tilemap entry per horizontal tile over a req/ack memory port.
- It emits one draw command per tile, with line-buffer x position and tile bitmap address, to the line-buffer drawer over a valid/ready handshake.

---
 rtl/sprite_tile_fetcher.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/sprite_tile_fetcher.sv
// Sprite tile fetcher: walks the matcher's active list once per scanline,
// reads one tilemap entry per horizontal tile and hands one draw command
// per tile to the line-buffer drawer.
module sprite_tile_fetcher #(
  parameter int TMAP_AW     = 18,
  parameter int TCNT_W      = 4,
  parameter int MAX_SPRITES = 512
) (
  input  logic               clk_draw,
  input  logic               rst_draw_n,
  input  logic               line,
  output logic [8:0]         sprite_index,
  input  logic               sprite_valid,
  input  logic [TMAP_AW-1:0] spr_tilemap_addr,
  input  logic               spr_x_flip,
  input  logic [TCNT_W-1:0]  spr_tile_count,
  input  logic [11:0]        spr_lb_addr,
  input  logic [17:0]        spr_bitmap_addr,
  output logic               tmap_req,
  output logic [TMAP_AW-1:0] tmap_addr,
  input  logic               tmap_ack,
  input  logic [15:0]        tmap_data,
  output logic               tile_valid,
  input  logic               tile_ready,
  output logic [11:0]        tile_lb_addr,
  output logic [17:0]        tile_bitmap_addr,
  output logic               tile_x_flip,
  output logic               tile_last,
  output logic               busy,
  output logic               overrun
);

  // One extra index bit so "all MAX_SPRITES entries consumed" is representable.
  localparam int IDX_W = $clog2(MAX_SPRITES) + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_FETCH = 3'd3,
    ST_EMIT  = 3'd4,
    ST_DRAIN = 3'd5
  } state_e;

  state_e              state_q, state_d;

  logic [IDX_W-1:0]    idx_q;
  logic [TCNT_W-1:0]   k_q;
  logic [TCNT_W-1:0]   last_k_q;      // N-1, so N = 2^TCNT_W never overflows
  logic                flip_q;
  logic [11:0]         lb_q;
  logic [17:0]         bmp_q;
  logic [TMAP_AW-1:0]  tmap_addr_q;

  logic [11:0]         tile_lb_addr_q;
  logic [17:0]         tile_bitmap_addr_q;
  logic                tile_x_flip_q;
  logic                tile_last_q;

  logic                load_ok_s;
  logic                last_tile_s;
  logic                busy_s;
  logic                tmap_req_s;
  logic                tile_valid_s;
  logic                overrun_s;
  logic                load_take_s;
  logic                ack_take_s;
  logic                next_tile_s;
  logic                next_sprite_s;
  logic [TCNT_W-1:0]   tile_sel_s;
  logic [11:0]         lb_off_s;
  logic                unused_data_s;

  assign last_tile_s   = (k_q == last_k_q);
  assign load_ok_s     = sprite_valid && (idx_q < IDX_W'(MAX_SPRITES));
  assign unused_data_s = ^tmap_data[14:10];

  // State register.
  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a line pulse restarts any walk in progress.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (line) state_d = ST_SEL;
        else      state_d = ST_IDLE;
      end
      ST_SEL: begin
        if (line) state_d = ST_SEL;
        else      state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (line)           state_d = ST_SEL;
        else if (load_ok_s) state_d = ST_FETCH;
        else                state_d = ST_IDLE;
      end
      ST_FETCH: begin
        // An abandoned request still owes us an ack before we may restart.
        if (line) begin
          if (tmap_ack) state_d = ST_SEL;
          else          state_d = ST_DRAIN;
        end else if (tmap_ack) begin
          state_d = ST_EMIT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EMIT: begin
        if (line) begin
          state_d = ST_SEL;
        end else if (tile_ready) begin
          if (last_tile_s) state_d = ST_SEL;
          else             state_d = ST_FETCH;
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_DRAIN: begin
        if (tmap_ack) state_d = ST_SEL;
        else          state_d = ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode and datapath strobes.
  always_comb begin
    busy_s        = (state_q != ST_IDLE);
    tmap_req_s    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    tile_valid_s  = (state_q == ST_EMIT);
    overrun_s     = line && busy_s;
    load_take_s   = (state_q == ST_LOAD)  && !line && load_ok_s;
    ack_take_s    = (state_q == ST_FETCH) && !line && tmap_ack;
    next_tile_s   = (state_q == ST_EMIT)  && !line && tile_ready && !last_tile_s;
    next_sprite_s = (state_q == ST_EMIT)  && !line && tile_ready && last_tile_s;
  end

  // Screen-x tile slot: mirrored order when the sprite is flipped.
  always_comb begin
    if (flip_q) begin
      tile_sel_s = last_k_q - k_q;
    end else begin
      tile_sel_s = k_q;
    end
    lb_off_s = 12'({tile_sel_s, 4'b0000});
  end

  // Active-list walk index.
  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      idx_q <= '0;
    end else if (line) begin
      idx_q <= '0;
    end else if (next_sprite_s) begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  // Per-sprite fields and the tile counter / tilemap address walk.
  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      k_q         <= '0;
      last_k_q    <= '0;
      flip_q      <= 1'b0;
      lb_q        <= 12'd0;
      bmp_q       <= 18'd0;
      tmap_addr_q <= '0;
    end else if (load_take_s) begin
      k_q         <= '0;
      last_k_q    <= spr_tile_count;
      flip_q      <= spr_x_flip;
      lb_q        <= spr_lb_addr;
      bmp_q       <= spr_bitmap_addr;
      tmap_addr_q <= spr_tilemap_addr;
    end else if (next_tile_s) begin
      k_q         <= k_q + TCNT_W'(1);
      tmap_addr_q <= tmap_addr_q + TMAP_AW'(1);
    end
  end

  // Draw command, captured when the tilemap entry arrives.
  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      tile_lb_addr_q     <= 12'd0;
      tile_bitmap_addr_q <= 18'd0;
      tile_x_flip_q      <= 1'b0;
      tile_last_q        <= 1'b0;
    end else if (ack_take_s) begin
      tile_lb_addr_q     <= lb_q + lb_off_s;
      tile_bitmap_addr_q <= bmp_q + {8'd0, tmap_data[9:0]};
      tile_x_flip_q      <= flip_q ^ tmap_data[15];
      tile_last_q        <= last_tile_s;
    end
  end

  assign sprite_index     = 9'(idx_q);
  assign tmap_req         = tmap_req_s;
  assign tmap_addr        = tmap_addr_q;
  assign tile_valid       = tile_valid_s;
  assign tile_lb_addr     = tile_lb_addr_q;
  assign tile_bitmap_addr = tile_bitmap_addr_q;
  assign tile_x_flip      = tile_x_flip_q;
  assign tile_last        = tile_last_q;
  assign busy             = busy_s;
  assign overrun          = overrun_s;

endmodule
